// File: rtl/spi_reg_pkg.sv
// Shared constants, FSM state encoding and frame builder for the SPI register link.
// The slave side of the link uses the same constants.
package spi_reg_pkg;

    localparam int FRAME_BITS = 40;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 32;
    localparam int RW_BIT     = 39;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_e;

    // Assemble the on-wire frame: rw, then address, then data (zeros for reads).
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic              rw,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdat
    );
        logic [FRAME_BITS-1:0] frame;
        frame                       = '0;
        frame[RW_BIT]               = rw;
        frame[RW_BIT-1 -: ADDR_W]   = addr;
        frame[DATA_W-1:0]           = rw ? '0 : wdat;
        return frame;
    endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// SCLK phase timer: counts DIV-cycle phases while enabled and, when sclk_run is
// set, toggles SCLK at each phase boundary and flags the rising/falling edges
// one cycle before they appear on the pin.
module spi_sclk_div #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic sclk_run,
    output logic tick,
    output logic rise,
    output logic fall,
    output logic sclk
);

    localparam int CNT_W = 8;

    logic [CNT_W-1:0] cnt;

    assign tick = enable && (cnt == CNT_W'(DIV - 1));
    assign rise = sclk_run && tick && !sclk;
    assign fall = sclk_run && tick && sclk;

    // Phase counter: held at zero while idle so every frame starts on a fresh phase.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // SCLK register: parked low outside the shift window, toggled on phase boundaries.
    always_ff @(posedge clk) begin
        if (reset || !sclk_run) begin
            sclk <= 1'b0;
        end else if (tick) begin
            sclk <= ~sclk;
        end
    end

endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-0 register master: sends a 40-bit command/data frame and, for reads,
// returns the last 32 bits clocked in on MISO.
module spi_reg_master
    import spi_reg_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdat,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdat,
    output logic              spi_csl,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    spi_state_e state;
    spi_state_e state_next;

    logic                  tick;
    logic                  sclk_rise;
    logic                  sclk_fall;
    logic                  div_en;
    logic                  sclk_run;
    logic                  capture;
    logic                  last_bit;
    logic                  frame_end;
    logic                  active_next;
    logic                  rw_q;
    logic [FRAME_BITS-1:0] frame_in;
    logic [FRAME_BITS-1:0] tx_shift;
    logic [DATA_W-1:0]     rx_shift;
    logic [BIT_CNT_W-1:0]  bit_cnt;

    assign frame_in    = build_frame(rw, addr, wdat);
    assign capture     = (state == IDLE) && start;
    assign div_en      = (state != IDLE);
    assign sclk_run    = (state == SHIFT);
    assign last_bit    = sclk_fall && (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));
    assign frame_end   = (state == HOLD) && tick;
    assign active_next = (state_next == SETUP) || (state_next == SHIFT) || (state_next == HOLD);

    spi_sclk_div #(
        .DIV (DIV)
    ) u_sclk_div (
        .clk      (clk),
        .reset    (reset),
        .enable   (div_en),
        .sclk_run (sclk_run),
        .tick     (tick),
        .rise     (sclk_rise),
        .fall     (sclk_fall),
        .sclk     (spi_sclk)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: each non-idle state lasts whole SCLK phases.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (capture)  state_next = SETUP;
            SETUP:   if (tick)     state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = HOLD;
            HOLD:    if (tick)     state_next = GAP;
            GAP:     if (tick)     state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // Registered status and chip select, derived from where the FSM is heading.
    always_ff @(posedge clk) begin
        if (reset) begin
            spi_csl <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            spi_csl <= !active_next;
            busy    <= (state_next != IDLE);
            done    <= frame_end;
        end
    end

    // Transmit path: first bit presented at capture, later bits on SCLK falls.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_shift <= '0;
            spi_mosi <= 1'b0;
            bit_cnt  <= '0;
            rw_q     <= 1'b0;
        end else if (capture) begin
            spi_mosi <= frame_in[FRAME_BITS-1];
            tx_shift <= {frame_in[FRAME_BITS-2:0], 1'b0};
            bit_cnt  <= '0;
            rw_q     <= rw;
        end else if (!active_next) begin
            spi_mosi <= 1'b0;
        end else if (sclk_fall) begin
            spi_mosi <= tx_shift[FRAME_BITS-1];
            tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
            bit_cnt  <= bit_cnt + 1'b1;
        end
    end

    // Receive path: a 32-bit window so the command-byte samples fall off the top.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_shift <= '0;
        end else if (sclk_rise) begin
            rx_shift <= {rx_shift[DATA_W-2:0], spi_miso};
        end
    end

    // Read result: committed only when a read frame completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdat <= '0;
        end else if (frame_end && rw_q) begin
            rdat <= rx_shift;
        end
    end

endmodule

// File: tb/tb_spi_reg_master.sv
// Scoreboard bench for spi_reg_master: a DIV=4 instance with a modelled slave,
// plus a DIV=2 instance wired MOSI->MISO.
module tb_spi_reg_master;

    localparam int DIV    = 4;
    localparam int LB_DIV = 2;

    typedef struct {
        logic [39:0] frame;
        logic [31:0] rdat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        rw = 1'b0;
    logic [6:0]  addr = '0;
    logic [31:0] wdat = '0;
    logic        busy;
    logic        done;
    logic [31:0] rdat;
    logic        spi_csl;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    logic        lb_start = 1'b0;
    logic        lb_rw = 1'b0;
    logic [6:0]  lb_addr = '0;
    logic [31:0] lb_wdat = '0;
    logic        lb_busy;
    logic        lb_done;
    logic [31:0] lb_rdat;
    logic        lb_csl;
    logic        lb_sclk;
    logic        lb_mosi;

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          t0 = 0;
    int          rel = 0;
    int          base = 0;

    exp_t        sb_q[$];
    exp_t        mon_exp;
    logic [31:0] model_rdat = '0;
    logic [31:0] slave_resp = '0;
    logic [39:0] slave_word;
    int          slave_idx = 0;

    logic        mon_en = 1'b0;
    logic        prev_csl = 1'b1;
    logic        prev_sclk = 1'b0;
    logic        prev_mosi = 1'b0;
    logic [39:0] mon_frame = '0;
    int          mon_rises = 0;
    int          csl_fall_cyc = 0;
    int          csl_rise_cyc = 0;
    logic        have_rise = 1'b0;
    logic        b2b_mode = 1'b0;
    int          frame_count = 0;
    int          done_events = 0;
    int          done_len = 0;

    spi_reg_master #(
        .DIV (DIV)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rw       (rw),
        .addr     (addr),
        .wdat     (wdat),
        .busy     (busy),
        .done     (done),
        .rdat     (rdat),
        .spi_csl  (spi_csl),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    spi_reg_master #(
        .DIV (LB_DIV)
    ) u_lb (
        .clk      (clk),
        .reset    (reset),
        .start    (lb_start),
        .rw       (lb_rw),
        .addr     (lb_addr),
        .wdat     (lb_wdat),
        .busy     (lb_busy),
        .done     (lb_done),
        .rdat     (lb_rdat),
        .spi_csl  (lb_csl),
        .spi_sclk (lb_sclk),
        .spi_mosi (lb_mosi),
        .spi_miso (lb_mosi)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Drive one request and push the frames it should produce onto the scoreboard.
    task automatic applyStimulus(input logic r, input logic [6:0] a, input logic [31:0] d, input int frames);
        exp_t e;
        @(negedge clk);
        rw    = r;
        addr  = a;
        wdat  = d;
        start = 1'b1;
        t0    = cyc;
        for (int i = 0; i < frames; i++) begin
            e.frame = r ? {1'b1, a, 32'h0} : {1'b0, a, d};
            if (r) model_rdat = slave_resp;
            e.rdat  = model_rdat;
            sb_q.push_back(e);
        end
    endtask

    task automatic waitDone(input bit noise, input bit keep, output int rel_out);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
            rel_out = cyc - t0;
            if (noise && (rel_out == 10 || rel_out == 100 || rel_out == 328)) begin
                rw    = 1'b1;
                addr  = 7'h7F;
                wdat  = 32'hFFFF_FFFF;
                start = 1'b1;
            end else if (!keep) begin
                start = 1'b0;
            end
        end while (!done && guard < 2000);
        checkOutput("done_seen", done, 1);
    endtask

    task automatic waitIdle(output int rel_out);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
            rel_out = cyc - t0;
        end while (busy && guard < 2000);
        checkOutput("idle_seen", busy, 0);
    endtask

    task automatic runLoopback();
        int          t0l;
        int          guard;
        int          rises;
        int          last_rise;
        logic        prev;
        logic [39:0] frame;
        @(negedge clk);
        lb_rw     = 1'b1;
        lb_addr   = 7'h55;
        lb_wdat   = 32'hAAAA_AAAA;
        lb_start  = 1'b1;
        t0l       = cyc;
        guard     = 0;
        rises     = 0;
        last_rise = 0;
        prev      = 1'b0;
        frame     = '0;
        do begin
            @(negedge clk);
            lb_start = 1'b0;
            guard++;
            if (!prev && lb_sclk) begin
                if (rises == 0) checkOutput("lb_first_rise", cyc - t0l, 5);
                else            checkOutput("lb_period", cyc - last_rise, 2 * LB_DIV);
                last_rise = cyc;
                rises++;
                frame = {frame[38:0], lb_mosi};
            end
            if (prev && !lb_sclk) checkOutput("lb_high", cyc - last_rise, LB_DIV);
            prev = lb_sclk;
        end while (!lb_done && guard < 1000);
        checkOutput("lb_done_cycle", cyc - t0l, 82 * LB_DIV + 1);
        checkOutput("lb_rises", rises, 40);
        checkOutput("lb_cmd_byte", frame[39:32], 8'hD5);
        checkOutput("lb_data_bits", frame[31:0], 32'h0);
        checkOutput("lb_rdat", lb_rdat, 32'h0);
    endtask

    // Frame monitor, scoreboard pop on done, and the mode-0 slave model.
    always @(negedge clk) begin
        slave_word = {8'hFF, slave_resp};
        if (mon_en) begin
            if (prev_csl && !spi_csl) begin
                if (b2b_mode && have_rise) checkOutput("b2b_gap", cyc - csl_rise_cyc, DIV + 1);
                mon_frame    = '0;
                mon_rises    = 0;
                csl_fall_cyc = cyc;
                frame_count++;
            end
            if (!prev_csl && spi_csl) begin
                csl_rise_cyc = cyc;
                have_rise    = 1'b1;
                checkOutput("mosi_idle", spi_mosi, 0);
            end
            if (!spi_csl && !prev_sclk && spi_sclk) begin
                mon_frame = {mon_frame[38:0], spi_mosi};
                mon_rises++;
            end
            if (!spi_csl && !prev_csl && (spi_mosi != prev_mosi) && !(prev_sclk && !spi_sclk))
                checkOutput("mosi_edge", spi_mosi, prev_mosi);
            done_len = done ? done_len + 1 : 0;
            if (done_len > 1) checkOutput("done_width", done_len, 1);
            if (done_len == 1) begin
                done_events++;
                if (sb_q.size() == 0) begin
                    checkOutput("sb_empty_at_done", sb_q.size(), 1);
                end else begin
                    mon_exp = sb_q.pop_front();
                    checkOutput("frame", mon_frame, mon_exp.frame);
                    checkOutput("cmd_byte", mon_frame[39:32], mon_exp.frame[39:32]);
                    checkOutput("sclk_rises", mon_rises, 40);
                    checkOutput("rdat", rdat, mon_exp.rdat);
                    checkOutput("done_latency", cyc - csl_fall_cyc, 82 * DIV);
                    checkOutput("csl_at_done", spi_csl, 1);
                end
            end
        end
        if (spi_csl) slave_idx = 0;
        else if (prev_sclk && !spi_sclk) slave_idx++;
        spi_miso  = (slave_idx < 40) ? slave_word[39 - slave_idx] : 1'b0;
        prev_csl  = spi_csl;
        prev_sclk = spi_sclk;
        prev_mosi = spi_mosi;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("rst_csl", spi_csl, 1);
        checkOutput("rst_sclk", spi_sclk, 0);
        checkOutput("rst_mosi", spi_mosi, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_rdat", rdat, 0);
        checkOutput("rst_lb_csl", lb_csl, 1);
        reset  = 1'b0;
        mon_en = 1'b1;

        $display("[TB] write addr 0x01 data 0x00000004");
        slave_resp = 32'h5A5A_5A5A;
        applyStimulus(1'b0, 7'h01, 32'h0000_0004, 1);
        waitDone(1'b0, 1'b0, rel);
        checkOutput("wr_csl_fall_cycle", csl_fall_cyc - t0, 1);
        checkOutput("wr_done_cycle", rel, 82 * DIV + 1);
        waitIdle(rel);
        checkOutput("wr_busy_low_cycle", rel, 83 * DIV + 1);

        $display("[TB] read addr 0x00, slave returns 0xB00F0001");
        slave_resp = 32'hB00F_0001;
        applyStimulus(1'b1, 7'h00, 32'h1234_5678, 1);
        waitDone(1'b0, 1'b0, rel);
        checkOutput("rd_rdat", rdat, 32'hB00F_0001);
        waitIdle(rel);

        $display("[TB] write with start pulses during the frame");
        base = frame_count;
        applyStimulus(1'b0, 7'h2A, 32'hCAFE_F00D, 1);
        waitDone(1'b1, 1'b0, rel);
        start = 1'b0;
        waitIdle(rel);
        repeat (20) @(negedge clk);
        checkOutput("noise_frames", frame_count - base, 1);
        checkOutput("noise_sb_empty", sb_q.size(), 0);

        $display("[TB] back-to-back reads with start held");
        slave_resp = 32'h1234_5678;
        have_rise  = 1'b0;
        b2b_mode   = 1'b1;
        base       = done_events;
        applyStimulus(1'b1, 7'h33, 32'h0, 3);
        for (int i = 0; i < 3; i++) waitDone(1'b0, 1'b1, rel);
        start = 1'b0;
        waitIdle(rel);
        b2b_mode = 1'b0;
        checkOutput("b2b_done_count", done_events - base, 3);
        checkOutput("b2b_sb_empty", sb_q.size(), 0);

        $display("[TB] reset during a read");
        slave_resp = 32'hFFFF_0000;
        applyStimulus(1'b1, 7'h10, 32'h0, 1);
        while (cyc - t0 < 150) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        start = 1'b1;
        rw    = 1'b0;
        addr  = 7'h7E;
        wdat  = 32'h0F0F_0F0F;
        void'(sb_q.pop_back());
        model_rdat = '0;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        checkOutput("abort_csl", spi_csl, 1);
        checkOutput("abort_sclk", spi_sclk, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_rdat", rdat, 0);
        base = done_events;
        repeat (400) @(negedge clk);
        checkOutput("abort_no_done", done_events - base, 0);

        $display("[TB] write after reset");
        applyStimulus(1'b0, 7'h7F, 32'h8000_0001, 1);
        waitDone(1'b0, 1'b0, rel);
        checkOutput("post_rst_done_cycle", rel, 82 * DIV + 1);
        waitIdle(rel);

        $display("[TB] DIV=2 loopback read addr 0x55");
        runLoopback();

        repeat (5) @(negedge clk);
        checkOutput("final_sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_reg_master.md
SPI_REG_MASTER -- requirements
Module: spi_reg_master

Interface
REQ-001 SHALL have parameter DIV, default 4, giving the SCLK half-period in clk cycles; legal range 2..255.
REQ-002 SHALL have port clk, input, 1 bit: system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: transaction request, sampled only while busy=0.
REQ-005 SHALL have port rw, input, 1 bit: 1 = read, 0 = write; captured with start.
REQ-006 SHALL have port addr, input, 7 bits: register address; captured with start.
REQ-007 SHALL have port wdat, input, 32 bits: write data; captured with start.
REQ-008 SHALL have port busy, output, 1 bit: transaction in progress, including the inter-frame gap.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse at end of frame.
REQ-010 SHALL have port rdat, output, 32 bits: last read result.
REQ-011 SHALL have ports spi_csl, spi_sclk and spi_mosi, outputs, 1 bit each: SPI chip select (active-low), serial clock and master-out data.
REQ-012 SHALL have port spi_miso, input, 1 bit: slave-out data, already synchronous to clk.

Function
REQ-013 SHALL emit a 40-bit frame, MSB first, in SPI mode 0: bit39 = rw, bits38:32 = addr, bits31:0 = wdat (write) or don't-care zeros (read).
REQ-014 SHALL use the FSM states IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
REQ-015 SHALL, in IDLE with start=1 at cycle 0, capture rw/addr/wdat and, at cycle 1, drive spi_csl=0 and busy=1, with spi_mosi = frame bit39, then enter SETUP.
REQ-016 SHALL hold SETUP for DIV cycles with spi_sclk=0.
REQ-017 SHALL, in SHIFT, generate 40 SCLK periods, each DIV cycles low followed by DIV cycles high.
REQ-018 SHALL change spi_mosi only on SCLK falling edges.
REQ-019 SHALL sample spi_miso in the clk cycle SCLK rises.
REQ-020 SHALL leave spi_sclk=0 after the 40th high phase and hold HOLD for DIV cycles with spi_csl still 0.
REQ-021 SHALL, at cycle 82*DIV+1 (start at cycle 0), drive spi_csl=1, pulse done for exactly one cycle, and enter GAP.
REQ-022 SHALL hold GAP for DIV cycles with busy=1, then return to IDLE with busy=0.
REQ-023 SHALL, for a read, load rdat with the final 32 MISO samples (bits 31..0) in the same cycle done pulses; the 8 samples taken during the command byte are discarded.
REQ-024 SHALL leave rdat unchanged for writes.
REQ-025 SHALL ignore start while busy=1; requests are neither queued nor corrupted.
REQ-026 SHALL accept start asserted in the first cycle after busy falls.
REQ-027 SHALL drive spi_mosi=0 whenever spi_csl=1.
REQ-028 SHALL keep SCLK free of glitches and keep each phase exactly DIV cycles, including the first and last bits.

Reset
REQ-029 SHALL, on reset, set spi_csl=1, spi_sclk=0, spi_mosi=0, busy=0, done=0, rdat=0 and the state to IDLE, one cycle after reset is sampled high.
REQ-030 SHALL, on reset mid-frame, abort without a done pulse, release spi_csl=1 at the next edge and preserve no partial rdat update.
REQ-031 SHALL ignore start in a cycle where reset=1.

Structure
REQ-032 SHALL take from a shared package spi_reg_pkg: FRAME_BITS=40, ADDR_W=7, DATA_W=32, RW_BIT=39 and the FSM state enumeration; the same constants serve the existing slave side.
REQ-033 SHALL place the DIV-cycle phase counter and the rise/fall strobe generator in one sub-module, spi_sclk_div, which has an enable input and rise/fall strobe outputs.
REQ-034 SHALL keep the frame shift register, bit counter and FSM in the top module.

Verification
REQ-035 SHALL verify a write: DIV=4, rw=0, addr=0x01, wdat=0x00000004 -> MOSI decodes 0x01_00000004, 40 rising edges, done at cycle 329, rdat unchanged, busy low at cycle 333.
REQ-036 SHALL verify a read: rw=1, addr=0x00, bench slave returns 0xB00F0001 on MISO -> rdat=0xB00F0001 in the done cycle, command byte on MOSI = 0x80.
REQ-037 SHALL verify start pulsed at cycles 10, 100 and 328 during a frame -> exactly one frame emitted, with captured fields unchanged.
REQ-038 SHALL verify back-to-back frames: start held high continuously -> spi_csl high for exactly DIV+1 cycles between frames (DIV gap cycles plus one restart cycle), with no done pulses lost.
REQ-039 SHALL verify reset asserted at cycle 150 of a read -> spi_csl=1, spi_sclk=0 next cycle, no done pulse, rdat=0, and a subsequent write completes normally.
REQ-040 SHALL verify DIV=2 with alternating-bit data 0xAAAAAAAA loopback MOSI->MISO on a read with addr=0x55 -> SCLK periods all 4 cycles and rdat equal to the looped-back bits 0x00000000.
